gpo_timed: RTL and testbench
============================

# gpo_timed

Memory-mapped general-purpose output slot core, the output-side companion to the general-purpose input core on the same MMIO slot bus. Holds a W-bit output register updated by whole-word write or by atomic set/clear/toggle masks. Also provides a retriggerable timed pulse engine that inverts selected output bits for a programmed number of clock cycles. Sits in an MMIO slot and drives board-level outputs such as LEDs, strobes and enables.

## Interface
- W, 8: output width, 1..31.
- CW, 16: pulse length counter width, 1..32.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  slot select.
- read  in  1  read strobe; reads have no side effects.
- write  in  1  write strobe; a write is accepted at a rising edge when cs & write.
- addr  in  5  word address within the slot.
- wr_data  in  32  write data.
- rd_data  out  32  read data, combinational mux on addr.
- dout  out  W  registered external outputs.

## Operation
- Register map (addr):
  - 0 DATA: a write sets base = wr_data[W-1:0]. A read returns base.
  - 1 SET: a write does base |= wr_data[W-1:0].
  - 2 CLR: a write does base &= ~wr_data[W-1:0].
  - 3 TGL: a write does base ^= wr_data[W-1:0].
  - 4 PLEN: a write sets len = wr_data[CW-1:0]. A read returns len, zero-extended.
  - 5 PULSE: a write starts a pulse with mask = wr_data[W-1:0]. A read returns {busy, 0..., mask}, with busy at bit 31.
  - 6 STATUS: a read returns {31'b0, busy}. Writes are ignored.
  - 7..31: reads return 0; writes are ignored.
- Unused rd_data bits above W (or above CW) read 0.
- Pulse FSM has two states, IDLE and PULSE; busy = (state == PULSE).
  - IDLE to PULSE: on a PULSE write with len != 0. Loads cnt = len and latches mask.
  - A PULSE write with len == 0 latches mask but stays in IDLE; no pulse is produced.
  - PULSE: cnt decrements each cycle. At cnt == 1 the FSM returns to IDLE and cnt becomes 0.
  - A PULSE write while in PULSE retriggers: cnt reloads to len and mask is replaced. Retrigger takes priority over expiry in the same cycle.
- Output: dout <= base_next ^ (busy_next ? mask_next : 0).
- Writes to base (addresses 0..3) during a pulse take effect immediately; the pulse inversion stays overlaid on the new base.
- Writing PLEN during a pulse does not affect the running count, only later triggers.

## Timing
- Reset values: dout = 0, base = 0, len = 0, mask = 0, cnt = 0, state = IDLE. rd_data follows its mux, which reads 0 at every address after reset.
- A write accepted at edge E updates dout at edge E, with no extra latency.
- A PULSE write at edge E0 with len = N inverts the mask bits of dout from E0 through edge E0+N, so the inversion lasts exactly N clock periods. busy reads 1 for the same N cycles.
- Reset asserted mid-pulse: the FSM returns to IDLE and dout = 0 immediately (asynchronous).
- rd_data reflects register state updated at the previous edge.

## Configuration
- GPO_PULSE_EN defined: the pulse engine, PLEN, PULSE and STATUS registers are present as described.
- GPO_PULSE_EN undefined: no counter or FSM is built. Addresses 4..6 read 0 and ignore writes. dout <= base_next, and busy is constant 0.

## Test plan
- Reset, then write DATA = 0xA5 -> dout = 0xA5 at the same edge, read addr 0 = 0x000000A5.
- From 0xA5: SET 0x0F -> 0xAF; CLR 0xA0 -> 0x0F; TGL 0xFF -> 0xF0. Read of addr 7 = 0.
- PLEN = 4, base = 0x00, PULSE 0x81 -> dout = 0x81 for exactly 4 cycles, then 0x00. STATUS = 1 for those 4 cycles, then 0.
- PLEN = 10, PULSE 0x01; at cycle 3 PULSE 0x02 -> bit0 drops and bit1 is high for 10 cycles from the retrigger. A retrigger on the expiry cycle extends the pulse. PLEN = 0 with PULSE 0xFF -> no output change, busy = 0.
- Mid-pulse DATA = 0xF0 with mask 0x81 -> dout = 0x71 until expiry, then 0xF0. Assert reset mid-pulse -> dout = 0 and STATUS = 0 immediately.
- Build without GPO_PULSE_EN: PULSE 0xFF -> dout unchanged; reads of addr 4..6 = 0.

Source files
------------

// File: rtl/gpo_timed.sv
// MMIO general-purpose output slot: a W-bit output register with set/clear/toggle access.
// Define GPO_PULSE_EN to add the retriggerable timed-pulse engine and its PLEN, PULSE and STATUS registers.
module gpo_timed #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] dout
);

    logic         we;
    logic [W-1:0] wr_word;
    logic [W-1:0] base_q, base_next;
    logic         unused;

    assign we      = cs & write;
    assign wr_word = wr_data[W-1:0];
    // Reads have no side effects, and the upper write-data bits are simply dropped.
    assign unused  = ^{read, wr_data};

    // NOTE: each next-value variable gets a default first, so this block cannot infer a latch.
    always_comb begin
        base_next = base_q;
        if (we) begin
            case (addr)
                5'd0:    base_next = wr_word;
                5'd1:    base_next = base_q | wr_word;
                5'd2:    base_next = base_q & ~wr_word;
                5'd3:    base_next = base_q ^ wr_word;
                default: base_next = base_q;
            endcase
        end
    end

`ifdef GPO_PULSE_EN
    typedef enum logic {IDLE, PULSE} state_t;

    state_t        state_q, state_next;
    logic [CW-1:0] cnt_q, cnt_next;
    logic [CW-1:0] len_q, len_next;
    logic [W-1:0]  mask_q, mask_next;
    logic          busy, busy_next;

    assign busy      = (state_q == PULSE);
    assign busy_next = (state_next == PULSE);

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        len_next   = len_q;
        mask_next  = mask_q;
        if (we && addr == 5'd4) begin
            len_next = wr_data[CW-1:0];
        end
        // A trigger wins over expiry; a zero length cancels instead of arming.
        if (we && addr == 5'd5) begin
            mask_next = wr_word;
            if (len_q != '0) begin
                state_next = PULSE;
                cnt_next   = len_q;
            end else begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end else if (state_q == PULSE) begin
            if (cnt_q == CW'(1)) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_q - 1'b1;
            end
        end
    end
`endif

    // NOTE: non-blocking assignments, so every register samples the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            dout    <= '0;
`ifdef GPO_PULSE_EN
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mask_q  <= '0;
`endif
        end else begin
            base_q  <= base_next;
`ifdef GPO_PULSE_EN
            state_q <= state_next;
            cnt_q   <= cnt_next;
            len_q   <= len_next;
            mask_q  <= mask_next;
            dout    <= base_next ^ (busy_next ? mask_next : '0);
`else
            dout    <= base_next;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: rd_data = 32'(base_q);
`ifdef GPO_PULSE_EN
            5'd4: rd_data = 32'(len_q);
            5'd5: begin
                rd_data     = 32'(mask_q);
                rd_data[31] = busy;
            end
            5'd6: rd_data[0] = busy;
`endif
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_gpo_timed.sv
// Self-checking bench for gpo_timed: directed scenarios plus random traffic against a
// cycle-count reference model. Expectations follow whether GPO_PULSE_EN is defined.
module tb_gpo_timed;

`ifdef GPO_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif
    localparam int W  = 8;
    localparam int CW = 16;
    localparam logic [31:0] WMASK = 32'((64'd1 << W) - 1);
    localparam logic [31:0] CMASK = 32'((64'd1 << CW) - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         cs, read, write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    // Reference state: remaining pulse cycles rather than any FSM encoding.
    logic [31:0] m_base, m_len, m_mask;
    int          m_rem;

    gpo_timed #(.W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_dout();
        return (m_rem > 0) ? (m_base ^ m_mask) : m_base;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic busy = (m_rem > 0);
        case (a)
            5'd0:    return m_base;
            5'd4:    return PULSE_EN ? m_len : 32'd0;
            5'd5:    return PULSE_EN ? ({busy, 31'd0} | m_mask) : 32'd0;
            5'd6:    return PULSE_EN ? {31'd0, busy} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_base = 0; m_len = 0; m_mask = 0; m_rem = 0;
    endtask

    task automatic m_edge(input logic w, input logic [4:0] a, input logic [31:0] d);
        bit trig = w && a == 5'd5 && PULSE_EN;
        if (w) begin
            case (a)
                5'd0: m_base = d & WMASK;
                5'd1: m_base = m_base | (d & WMASK);
                5'd2: m_base = m_base & ~d & WMASK;
                5'd3: m_base = m_base ^ (d & WMASK);
                5'd4: if (PULSE_EN) m_len = d & CMASK;
                default: ;
            endcase
        end
        if (trig) begin
            m_mask = d & WMASK;
            m_rem  = int'(m_len);
        end else if (m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic rd(input logic [4:0] a);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        #1;
        check($sformatf("rd_addr%0d", a), rd_data, m_read(a));
        cs = 1'b0; read = 1'b0;
    endtask

    // One clock: optional write, then check dout and STATUS one unit after the edge.
    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d);
        cs = w; write = w; read = 1'b0; addr = a; wr_data = d;
        @(posedge clk);
        m_edge(w, a, d);
        #1;
        check("dout", 32'(dout), m_dout());
        cs = 1'b0; write = 1'b0;
        rd(5'd6);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        m_reset();
        #12;
        check("reset_dout", 32'(dout), 32'd0);
        for (int a = 0; a < 8; a++) rd(5'(a));
        #10 reset = 1'b0;

        // Whole-word and atomic base updates.
        step(1'b1, 5'd0, 32'hA5); rd(5'd0);
        check("data_a5", 32'(dout), 32'hA5);
        step(1'b1, 5'd1, 32'h0F); check("set_0f", 32'(dout), 32'hAF);
        step(1'b1, 5'd2, 32'hA0); check("clr_a0", 32'(dout), 32'h0F);
        step(1'b1, 5'd3, 32'hFF); check("tgl_ff", 32'(dout), 32'hF0);
        rd(5'd7);

        // Basic pulse of length 4.
        step(1'b1, 5'd0, 32'h00);
        step(1'b1, 5'd4, 32'd4); rd(5'd4);
        step(1'b1, 5'd5, 32'h81); rd(5'd5);
        idle(6);

        // Retrigger mid-pulse with a new mask.
        step(1'b1, 5'd4, 32'd10);
        step(1'b1, 5'd5, 32'h01);
        idle(2);
        step(1'b1, 5'd5, 32'h02);
        idle(12);

        // Retrigger on the expiry cycle extends the pulse.
        step(1'b1, 5'd4, 32'd3);
        step(1'b1, 5'd5, 32'h04);
        idle(2);
        step(1'b1, 5'd5, 32'h08);
        idle(5);

        // Zero length: mask latched, nothing produced.
        step(1'b1, 5'd4, 32'd0);
        step(1'b1, 5'd5, 32'hFF); rd(5'd5);

        // Base write overlaid by a running pulse; PLEN change does not touch the count.
        step(1'b1, 5'd4, 32'd6);
        step(1'b1, 5'd5, 32'h81);
        step(1'b1, 5'd0, 32'hF0);
        if (PULSE_EN) check("overlay_71", 32'(dout), 32'h71);
        step(1'b1, 5'd4, 32'd2);
        idle(6);
        check("after_overlay", 32'(dout), 32'hF0);

        // Asynchronous reset in the middle of a pulse.
        step(1'b1, 5'd4, 32'd6);
        step(1'b1, 5'd5, 32'h81);
        idle(1);
        reset = 1'b1;
        m_reset();
        #1;
        check("async_reset_dout", 32'(dout), 32'd0);
        rd(5'd6);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic with short pulse lengths.
        for (int i = 0; i < 400; i++) begin
            logic        w;
            logic [4:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
            d = (a == 5'd4) ? 32'($urandom_range(0, 7)) : $urandom;
            step(w, a, d);
            rd(5'($urandom_range(0, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
